// File: rtl/usb_out_ep_buf_if.sv
// Bundles the packet-receiver side and the endpoint side of usb_out_ep_buf.
// The buffer uses the slave view; whatever drives packets and pops bytes uses the master view.
interface usb_out_ep_buf_if;
    logic       rx_pkt_start;
    logic       rx_setup;
    logic       rx_data_put;
    logic [7:0] rx_data;
    logic       rx_pkt_end;
    logic       rx_pkt_valid;
    logic       rx_data_toggle;
    logic       hs_ack;
    logic       hs_nak;
    logic       hs_stall;
    logic       ep_req;
    logic       ep_grant;
    logic       ep_data_avail;
    logic       ep_setup;
    logic       ep_data_get;
    logic [7:0] ep_data;
    logic       ep_stall;
    logic       ep_acked;

    modport slave (
        input  rx_pkt_start, rx_setup, rx_data_put, rx_data, rx_pkt_end,
        input  rx_pkt_valid, rx_data_toggle, ep_req, ep_data_get, ep_stall,
        output hs_ack, hs_nak, hs_stall, ep_grant, ep_data_avail, ep_setup,
        output ep_data, ep_acked
    );

    modport master (
        output rx_pkt_start, rx_setup, rx_data_put, rx_data, rx_pkt_end,
        output rx_pkt_valid, rx_data_toggle, ep_req, ep_data_get, ep_stall,
        input  hs_ack, hs_nak, hs_stall, ep_grant, ep_data_avail, ep_setup,
        input  ep_data, ep_acked
    );
endinterface

// File: rtl/usb_out_ep_buf.sv
// Single-packet OUT/SETUP receive buffer: stores one packet, picks ACK/NAK/STALL, replays bytes.
// Define USB_OUT_EP_TOGGLE_CHECK_EN to enable DATA0/DATA1 tracking and duplicate discard.
module usb_out_ep_buf #(
    parameter int MAX_PKT_SIZE = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    usb_out_ep_buf_if.slave bus
);
    localparam int PW = $clog2(MAX_PKT_SIZE) + 1;
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PKT_SIZE);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RECV  = 2'd1,
        ST_DROP  = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_buf [MAX_PKT_SIZE];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_len;
    logic [PW-1:0]   w_rd_next;
    logic            r_ovf;
    logic            r_rx_setup;
    logic            r_stall;
    logic            r_avail;
    logic            r_ep_setup;
    logic            r_grant;
    logic [7:0]      r_ep_data;
    logic            r_hs_ack;
    logic            r_hs_nak;
    logic            r_hs_stall;
    logic            r_acked;
    logic            w_hs_ack;
    logic            w_hs_nak;
    logic            w_hs_stall;
    logic            w_commit;
    logic            w_setup_start;
    logic            w_stall_eff;
    logic            w_tog_ok;
    logic            w_get;
    logic            w_wr_en;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
    logic            r_exp_toggle;
`endif

    assign w_rd_next = r_rd_ptr + PW'(1);

    // Next-state and handshake decision
    always_comb begin
        w_next_state  = r_state;
        w_hs_ack      = 1'b0;
        w_hs_nak      = 1'b0;
        w_hs_stall    = 1'b0;
        w_commit      = 1'b0;
        w_setup_start = bus.rx_pkt_start & bus.rx_setup;
        // A stall request arriving together with rx_pkt_end already applies to that packet
        w_stall_eff   = r_stall | bus.ep_stall;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
        w_tog_ok      = r_rx_setup | (bus.rx_data_toggle == r_exp_toggle);
`else
        w_tog_ok      = 1'b1;
`endif
        w_get   = bus.ep_data_get & r_grant & r_avail & ~w_setup_start &
                  ((r_state == ST_FULL) | (r_state == ST_DROP));
        w_wr_en = (r_state == ST_RECV) & bus.rx_data_put & ~bus.rx_pkt_start &
                  ~r_ovf & (r_wr_ptr < MAX_CNT);
        case (r_state)
            ST_EMPTY: begin
                if (bus.rx_pkt_start) begin
                    w_next_state = ST_RECV;
                end else begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_RECV: begin
                if (bus.rx_pkt_start) begin
                    w_next_state = ST_RECV;
                end else if (bus.rx_pkt_end) begin
                    if (!bus.rx_pkt_valid || r_ovf) begin
                        w_next_state = ST_EMPTY;
                    end else if (!r_rx_setup && w_stall_eff) begin
                        w_hs_stall   = 1'b1;
                        w_next_state = ST_EMPTY;
                    end else if (!w_tog_ok) begin
                        w_hs_ack     = 1'b1;
                        w_next_state = ST_EMPTY;
                    end else begin
                        w_hs_ack     = 1'b1;
                        w_commit     = 1'b1;
                        w_next_state = ST_FULL;
                    end
                end else begin
                    w_next_state = ST_RECV;
                end
            end
            ST_DROP: begin
                if (w_setup_start) begin
                    w_next_state = ST_RECV;
                end else if (bus.rx_pkt_end) begin
                    w_hs_nak     = bus.rx_pkt_valid;
                    w_next_state = ST_FULL;
                end else begin
                    w_next_state = ST_DROP;
                end
            end
            ST_FULL: begin
                if (w_setup_start) begin
                    w_next_state = ST_RECV;
                end else if (bus.rx_pkt_start) begin
                    w_next_state = r_avail ? ST_DROP : ST_RECV;
                end else if (!r_avail) begin
                    w_next_state = ST_EMPTY;
                end else begin
                    w_next_state = ST_FULL;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Packet storage (contents are don't-care until committed)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr[AW-1:0]] <= bus.rx_data;
        end
    end

    // Pointers, flags and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_rx_setup <= 1'b0;
            r_stall    <= 1'b0;
            r_avail    <= 1'b0;
            r_ep_setup <= 1'b0;
            r_grant    <= 1'b0;
            r_ep_data  <= 8'h00;
            r_hs_ack   <= 1'b0;
            r_hs_nak   <= 1'b0;
            r_hs_stall <= 1'b0;
            r_acked    <= 1'b0;
        end else begin
            r_hs_ack   <= w_hs_ack;
            r_hs_nak   <= w_hs_nak;
            r_hs_stall <= w_hs_stall;
            r_acked    <= w_commit;
            r_grant    <= bus.ep_req;
            r_stall    <= w_setup_start ? 1'b0 : (r_stall | bus.ep_stall);

            if (bus.rx_pkt_start && (w_next_state == ST_RECV)) begin
                r_wr_ptr   <= '0;
                r_ovf      <= 1'b0;
                r_rx_setup <= bus.rx_setup;
            end else if ((r_state == ST_RECV) && bus.rx_data_put) begin
                if (r_wr_ptr < MAX_CNT) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end

            if (w_setup_start) begin
                r_rd_ptr <= '0;
                r_avail  <= 1'b0;
            end else if (w_commit) begin
                r_len      <= r_wr_ptr;
                r_rd_ptr   <= '0;
                r_avail    <= (r_wr_ptr != '0);
                r_ep_setup <= r_rx_setup;
            end else if (w_get) begin
                r_ep_data <= r_buf[r_rd_ptr[AW-1:0]];
                r_rd_ptr  <= w_rd_next;
                r_avail   <= (w_rd_next != r_len);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
    // Expected data toggle; a SETUP commit re-arms it to DATA1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_exp_toggle <= 1'b0;
        end else if (w_commit) begin
            r_exp_toggle <= r_rx_setup ? 1'b1 : ~r_exp_toggle;
        end else begin
            r_exp_toggle <= r_exp_toggle;
        end
    end
`endif

    assign bus.hs_ack        = r_hs_ack;
    assign bus.hs_nak        = r_hs_nak;
    assign bus.hs_stall      = r_hs_stall;
    assign bus.ep_acked      = r_acked;
    assign bus.ep_grant      = r_grant;
    assign bus.ep_data_avail = r_avail;
    assign bus.ep_setup      = r_ep_setup;
    assign bus.ep_data       = r_ep_data;
endmodule
